neander_x2_control: RTL and testbench
=====================================

// Module: neander_x2_control
// PURPOSE
//  Next-generation NEANDER-X control FSM. Generalises the address width, so that
//  8-bit or 16-bit operands are fetched byte by byte, and supports variable-latency
//  memory through a mem_ready handshake. Adds halt/resume, NOP/illegal-opcode
//  handling and an explicit AC source select. Sits between RI/flags and the datapath.
// PARAMETERS
//  ADDR_W  8  Address width; legal values are 8 or 16, any other value is an elaboration error.
//             OPB = ADDR_W/8 operand bytes.
// PORTS
//  clk          in  1  Clock; single clock domain.
//  reset        in  1  Synchronous, active-high reset.
//  opcode       in  4  RI[7:4].
//  flagN        in  1  Negative flag.
//  flagZ        in  1  Zero flag.
//  mem_ready    in  1  Memory has completed the current read/write this cycle.
//  resume       in  1  Leave the HALT state.
//  mem_read     out 1  / mem_write out 1 / pc_inc out 1 / pc_load out 1 / ri_load out 1
//  rem_load     out 1  / rdm_load out 1 / ac_load out 1 / nz_load out 1 / io_write out 1
//  addr_sel_pc  out 1  1: REM<-PC, 0: REM<-RDM (full ADDR_W).
//  rdm_byte     out max(1,$clog2(OPB))  RDM byte lane written by rdm_load; 0 = LSB.
//  alu_op       out 2  00 ADD, 01 AND, 10 OR, 11 NOT.
//  ac_src       out 2  00 ALU, 01 memory data, 10 io_in.
//  halted       out 1  FSM is in HALT.
//  illegal_op   out 1  One-cycle pulse on an undefined opcode.
// BEHAVIOUR
//  - Outputs are Moore-decoded from state, except pc_load in J, which depends on flags.
//    Default values: all strobes 0, addr_sel_pc=1, alu_op=00, ac_src=00, rdm_byte=0.
//  - Reset: while reset=1, all outputs take their default values. On the first edge
//    with reset=1, state<=F1 and the byte counter <=0. A reset issued mid-wait aborts
//    the access with no further strobes.
//  - Fetch:
//    F1: rem_load, mem_read.
//    F2: mem_read held; on mem_ready: rdm_load, go to F3; otherwise stay in F2.
//    F3: ri_load, pc_inc.
//    DEC: dispatch on opcode.
//  - DEC dispatch:
//    0 NOP -> F1.  1 STA, 2 LDA, 3 ADD, 4 OR, 5 AND -> OA (memory ops).
//    6 NOT -> NT.  8 JMP, 9 JN, A JZ, B JNZ -> OA (jumps).
//    C IN, D OUT, E LDI -> IA (one-byte operand).  F -> HALT.
//    7 -> ILL, which pulses illegal_op and then goes to F1.
//  - Operand loop, repeated for byte counter cnt = 0..OPB-1:
//    OA: addr_sel_pc=1, rem_load, mem_read.
//    OB: mem_read held; on mem_ready: rdm_load, rdm_byte=cnt, pc_inc, then
//        cnt==OPB-1 ? cnt<=0, go to the exec state : cnt++, go to OA.
//  - Memory-op exec:
//    E1: addr_sel_pc=0, rem_load, with mem_read for every op except STA.
//    E2 (LDA/ADD/AND/OR): mem_read held; on mem_ready: ac_load, nz_load,
//        ac_src = 01 for LDA, else 00 with the matching alu_op.
//    E2 (STA): mem_write held until mem_ready.
//    All E2 variants go to F1 after mem_ready.
//  - J (jump exec): pc_load = JMP | (JN&flagN) | (JZ&flagZ) | (JNZ&!flagZ); then F1.
//    PC was already advanced past the operand, so a jump that is not taken needs no extra pc_inc.
//  - NT: ac_load, nz_load, alu_op=11; then F1.
//  - One-byte operand states:
//    IA: addr_sel_pc=1, rem_load, mem_read.
//    IB: wait for mem_ready, then pc_inc plus:
//        LDI: ac_load, nz_load, ac_src=01.
//        IN/OUT: rdm_load, rdm_byte=0.
//    IN continues to IX: ac_load, nz_load, ac_src=10.
//    OUT continues to OX: io_write for exactly 1 cycle.
//  - HALT: halted=1, no strobes. resume=1 -> F1 on the next edge. PC already points
//    past the HLT instruction.
//  - A wait state can last any number of cycles (no timeout). The strobes of a wait state
//    stay constant while it waits; its load strobes fire only in the mem_ready cycle.
//  - Latency with mem_ready=1: fetch+decode 4 cycles. Memory op 6+2*OPB. Jump 5+2*OPB.
//    NOT 5. LDI 6. IN/OUT 7.
// TESTING
//  1. ADDR_W=8, ready=1, LDA -> ac_load, nz_load, ac_src=01 in cycle 8; pc_inc in cycles 3 and 6.
//  2. ADDR_W=16, JMP -> rdm_load with rdm_byte 0 then 1, pc_inc twice, pc_load in cycle 9.
//  3. mem_ready=0 for 3 cycles in F2 -> mem_read held for 4 cycles; rdm_load only in the 4th; then F3.
//  4. JN with flagN=0 -> no pc_load, back to F1. JNZ with flagZ=0 -> pc_load=1.
//  5. HLT -> halted=1 and all strobes 0 for 10 cycles; resume pulse -> F1 next cycle.
//  6. Opcode 7 -> illegal_op high for 1 cycle. Reset during STA E2 wait -> mem_write=0 the next cycle, then F1.

Source files
------------

// File: rtl/neander_x2_control.sv
// NEANDER-X second-generation control FSM: byte-wise operand fetch for 8/16-bit
// addresses, mem_ready handshake on every memory access, halt/resume, NOP/illegal ops.
module neander_x2_control #(
    parameter  int ADDR_W = 8,
    localparam int OPB    = ADDR_W / 8,
    localparam int BYTE_W = (OPB > 1) ? $clog2(OPB) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    input  logic              flagN,
    input  logic              flagZ,
    input  logic              mem_ready,
    input  logic              resume,
    output logic              mem_read,
    output logic              mem_write,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              ri_load,
    output logic              rem_load,
    output logic              rdm_load,
    output logic              ac_load,
    output logic              nz_load,
    output logic              io_write,
    output logic              addr_sel_pc,
    output logic [BYTE_W-1:0] rdm_byte,
    output logic [1:0]        alu_op,
    output logic [1:0]        ac_src,
    output logic              halted,
    output logic              illegal_op
);

    if (ADDR_W != 8 && ADDR_W != 16) begin : g_bad_addr_w
        $error("neander_x2_control: ADDR_W must be 8 or 16");
    end

    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_IN  = 4'hC;
    localparam logic [3:0] OP_LDI = 4'hE;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(OPB - 1);

    typedef enum logic [3:0] {
        S_F1, S_F2, S_F3, S_DEC, S_OA, S_OB, S_E1, S_E2,
        S_J, S_NT, S_IA, S_IB, S_IX, S_OX, S_HALT, S_ILL
    } state_t;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_F1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no
        // path through the case below can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ri_load     = 1'b0;
        rem_load    = 1'b0;
        rdm_load    = 1'b0;
        ac_load     = 1'b0;
        nz_load     = 1'b0;
        io_write    = 1'b0;
        addr_sel_pc = 1'b1;
        rdm_byte    = '0;
        alu_op      = 2'b00;
        ac_src      = 2'b00;
        halted      = 1'b0;
        illegal_op  = 1'b0;

        // Reset forces all outputs to defaults, aborting any pending access.
        if (!reset) begin
            unique case (state_q)
                S_F1: begin
                    rem_load = 1'b1;
                    mem_read = 1'b1;
                    state_d  = S_F2;
                end
                S_F2: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        rdm_load = 1'b1;
                        state_d  = S_F3;
                    end
                end
                S_F3: begin
                    ri_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DEC;
                end
                S_DEC: begin
                    unique case (opcode)
                        4'h0:                                   state_d = S_F1;
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                        4'h8, 4'h9, 4'hA, 4'hB:                 state_d = S_OA;
                        4'h6:                                   state_d = S_NT;
                        4'h7:                                   state_d = S_ILL;
                        4'hC, 4'hD, 4'hE:                       state_d = S_IA;
                        default:                                state_d = S_HALT;
                    endcase
                end
                S_OA: begin
                    rem_load = 1'b1;
                    mem_read = 1'b1;
                    state_d  = S_OB;
                end
                S_OB: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        rdm_load = 1'b1;
                        rdm_byte = cnt_q;
                        pc_inc   = 1'b1;
                        if (cnt_q == LAST_BYTE) begin
                            cnt_d   = '0;
                            state_d = opcode[3] ? S_J : S_E1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_OA;
                        end
                    end
                end
                S_E1: begin
                    addr_sel_pc = 1'b0;
                    rem_load    = 1'b1;
                    mem_read    = (opcode != OP_STA);
                    state_d     = S_E2;
                end
                S_E2: begin
                    mem_write = (opcode == OP_STA);
                    mem_read  = (opcode != OP_STA);
                    if (mem_ready) begin
                        state_d = S_F1;
                        if (opcode != OP_STA) begin
                            ac_load = 1'b1;
                            nz_load = 1'b1;
                            ac_src  = (opcode == OP_LDA) ? 2'b01 : 2'b00;
                            alu_op  = (opcode == OP_AND) ? 2'b01 :
                                      (opcode == OP_OR)  ? 2'b10 : 2'b00;
                        end
                    end
                end
                S_J: begin
                    pc_load = (opcode == OP_JMP) || ((opcode == OP_JN) && flagN) ||
                              ((opcode == OP_JZ) && flagZ) || ((opcode == OP_JNZ) && !flagZ);
                    state_d = S_F1;
                end
                S_NT: begin
                    ac_load = 1'b1;
                    nz_load = 1'b1;
                    alu_op  = 2'b11;
                    state_d = S_F1;
                end
                S_IA: begin
                    rem_load = 1'b1;
                    mem_read = 1'b1;
                    state_d  = S_IB;
                end
                S_IB: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        pc_inc = 1'b1;
                        if (opcode == OP_LDI) begin
                            ac_load = 1'b1;
                            nz_load = 1'b1;
                            ac_src  = 2'b01;
                            state_d = S_F1;
                        end else begin
                            rdm_load = 1'b1;
                            state_d  = (opcode == OP_IN) ? S_IX : S_OX;
                        end
                    end
                end
                S_IX: begin
                    ac_load = 1'b1;
                    nz_load = 1'b1;
                    ac_src  = 2'b10;
                    state_d = S_F1;
                end
                S_OX: begin
                    io_write = 1'b1;
                    state_d  = S_F1;
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (resume) state_d = S_F1;
                end
                S_ILL: begin
                    illegal_op = 1'b1;
                    state_d    = S_F1;
                end
                default: state_d = S_F1;
            endcase
        end
    end

endmodule

// File: tb/tb_neander_x2_control.sv
// Directed bench for neander_x2_control: per-cycle expected output vectors for
// ADDR_W=8 and ADDR_W=16 instances, built from hand-derived state sequences.
module tb_neander_x2_control;

    // Output vector layout:
    // [17]mem_read [16]mem_write [15]pc_inc [14]pc_load [13]ri_load [12]rem_load
    // [11]rdm_load [10]ac_load [9]nz_load [8]io_write [7]addr_sel_pc [6]rdm_byte
    // [5:4]alu_op [3:2]ac_src [1]halted [0]illegal_op
    localparam logic [17:0] B_MR  = 18'h20000;
    localparam logic [17:0] B_MW  = 18'h10000;
    localparam logic [17:0] B_PI  = 18'h08000;
    localparam logic [17:0] B_PL  = 18'h04000;
    localparam logic [17:0] B_RI  = 18'h02000;
    localparam logic [17:0] B_RM  = 18'h01000;
    localparam logic [17:0] B_RD  = 18'h00800;
    localparam logic [17:0] B_AC  = 18'h00400;
    localparam logic [17:0] B_NZ  = 18'h00200;
    localparam logic [17:0] B_IO  = 18'h00100;
    localparam logic [17:0] B_AS  = 18'h00080;
    localparam logic [17:0] B_RB  = 18'h00040;
    localparam logic [17:0] A_AND = 18'h00010;
    localparam logic [17:0] A_OR  = 18'h00020;
    localparam logic [17:0] A_NOT = 18'h00030;
    localparam logic [17:0] S_MEM = 18'h00004;
    localparam logic [17:0] S_IO  = 18'h00008;
    localparam logic [17:0] B_HL  = 18'h00002;
    localparam logic [17:0] B_IL  = 18'h00001;
    localparam logic [17:0] DEF   = B_AS;
    localparam logic [17:0] E_F1  = B_AS | B_RM | B_MR;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        res;
        logic        n;
        logic        z;
        logic [3:0]  op;
        logic [17:0] exp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       flagN = 1'b0, flagZ = 1'b0, mem_ready = 1'b1, resume = 1'b0;

    logic mr8, mw8, pi8, pl8, ri8, rm8, rd8, ac8, nz8, io8, as8, hl8, il8;
    logic mr16, mw16, pi16, pl16, ri16, rm16, rd16, ac16, nz16, io16, as16, hl16, il16;
    logic [0:0] rb8, rb16;
    logic [1:0] alu8, src8, alu16, src16;
    logic [17:0] o8, o16;

    int    errors = 0;
    int    checks = 0;
    step_t seq[$];
    logic [3:0] cur_op;
    logic cur_n, cur_z;

    always #5 clk = ~clk;

    neander_x2_control #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset(reset), .opcode(opcode), .flagN(flagN), .flagZ(flagZ),
        .mem_ready(mem_ready), .resume(resume), .mem_read(mr8), .mem_write(mw8),
        .pc_inc(pi8), .pc_load(pl8), .ri_load(ri8), .rem_load(rm8), .rdm_load(rd8),
        .ac_load(ac8), .nz_load(nz8), .io_write(io8), .addr_sel_pc(as8),
        .rdm_byte(rb8), .alu_op(alu8), .ac_src(src8), .halted(hl8), .illegal_op(il8)
    );

    neander_x2_control #(.ADDR_W(16)) dut16 (
        .clk(clk), .reset(reset), .opcode(opcode), .flagN(flagN), .flagZ(flagZ),
        .mem_ready(mem_ready), .resume(resume), .mem_read(mr16), .mem_write(mw16),
        .pc_inc(pi16), .pc_load(pl16), .ri_load(ri16), .rem_load(rm16), .rdm_load(rd16),
        .ac_load(ac16), .nz_load(nz16), .io_write(io16), .addr_sel_pc(as16),
        .rdm_byte(rb16), .alu_op(alu16), .ac_src(src16), .halted(hl16), .illegal_op(il16)
    );

    assign o8  = {mr8, mw8, pi8, pl8, ri8, rm8, rd8, ac8, nz8, io8, as8, rb8, alu8, src8, hl8, il8};
    assign o16 = {mr16, mw16, pi16, pl16, ri16, rm16, rd16, ac16, nz16, io16, as16, rb16,
                  alu16, src16, hl16, il16};

    task automatic push(input logic rst, input logic rdy, input logic res, input logic [17:0] exp);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.res = res; s.n = cur_n; s.z = cur_z; s.op = cur_op; s.exp = exp;
        seq.push_back(s);
    endtask

    task automatic push_fetch(input logic [3:0] op, input logic n, input logic z);
        cur_op = op; cur_n = n; cur_z = z;
        push(0, 1, 0, E_F1);
        push(0, 1, 0, B_AS | B_MR | B_RD);
        push(0, 1, 0, B_AS | B_RI | B_PI);
        push(0, 1, 0, B_AS);
    endtask

    task automatic push_operand(input int bytes);
        for (int b = 0; b < bytes; b++) begin
            push(0, 1, 0, E_F1);
            push(0, 1, 0, B_AS | B_MR | B_RD | B_PI | ((b == 1) ? B_RB : 18'h0));
        end
    endtask

    task automatic begin_seq();
        seq.delete();
        cur_op = 4'h0; cur_n = 1'b0; cur_z = 1'b0;
        push(1, 1, 0, DEF);
    endtask

    task automatic apply(input step_t s);
        reset = s.rst; mem_ready = s.rdy; resume = s.res;
        flagN = s.n; flagZ = s.z; opcode = s.op;
    endtask

    task automatic test_reset();
        begin_seq();
        cur_op = 4'hF; cur_n = 1'b1; cur_z = 1'b1;
        push(1, 1, 1, DEF);
        push(1, 0, 1, DEF);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks += 2;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL reset8 step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            if (o16 !== seq[i].exp) begin
                errors++;
                $display("FAIL reset16 step %0d: outputs=%h expected=%h", i, o16, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lda8();
        begin_seq();
        push_fetch(4'h2, 0, 0);
        push_operand(1);
        push(0, 1, 0, B_RM | B_MR);
        push(0, 1, 0, B_AS | B_MR | B_AC | B_NZ | S_MEM);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL lda8 step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_ops8();
        logic [3:0]  ops[3] = '{4'h3, 4'h4, 4'h5};
        logic [17:0] sel[3] = '{18'h0, A_OR, A_AND};
        begin_seq();
        for (int k = 0; k < 3; k++) begin
            push_fetch(ops[k], 0, 0);
            push_operand(1);
            push(0, 1, 0, B_RM | B_MR);
            push(0, 1, 0, B_AS | B_MR | B_AC | B_NZ | sel[k]);
        end
        push_fetch(4'h1, 0, 0);
        push_operand(1);
        push(0, 1, 0, B_RM);
        push(0, 0, 0, B_AS | B_MW);
        push(0, 0, 0, B_AS | B_MW);
        push(0, 1, 0, B_AS | B_MW);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL memops8 step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jmp16();
        begin_seq();
        push_fetch(4'h8, 0, 0);
        push_operand(2);
        push(0, 1, 0, B_AS | B_PL);
        push_fetch(4'h2, 0, 0);
        push(0, 1, 0, E_F1);
        push(0, 0, 0, B_AS | B_MR);
        push(0, 1, 0, B_AS | B_MR | B_RD | B_PI);
        push(0, 1, 0, E_F1);
        push(0, 1, 0, B_AS | B_MR | B_RD | B_PI | B_RB);
        push(0, 1, 0, B_RM | B_MR);
        push(0, 1, 0, B_AS | B_MR | B_AC | B_NZ | S_MEM);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o16 !== seq[i].exp) begin
                errors++;
                $display("FAIL jmp16 step %0d: outputs=%h expected=%h", i, o16, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_wait();
        begin_seq();
        cur_op = 4'h0;
        push(0, 0, 0, E_F1);
        for (int k = 0; k < 3; k++) push(0, 0, 0, B_AS | B_MR);
        push(0, 1, 0, B_AS | B_MR | B_RD);
        push(0, 1, 0, B_AS | B_RI | B_PI);
        push(0, 1, 0, B_AS);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL fetch_wait step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jumps();
        // {opcode, flagN, flagZ, taken}
        logic [6:0] cases[7] = '{{4'h9, 1'b0, 1'b0, 1'b0}, {4'hB, 1'b0, 1'b0, 1'b1},
                                 {4'h9, 1'b1, 1'b0, 1'b1}, {4'hA, 1'b0, 1'b1, 1'b1},
                                 {4'hA, 1'b0, 1'b0, 1'b0}, {4'hB, 1'b0, 1'b1, 1'b0},
                                 {4'h8, 1'b0, 1'b0, 1'b1}};
        begin_seq();
        for (int k = 0; k < 7; k++) begin
            push_fetch(cases[k][6:3], cases[k][2], cases[k][1]);
            push_operand(1);
            push(0, 1, 0, B_AS | (cases[k][0] ? B_PL : 18'h0));
        end
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL jumps step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_short_ops();
        begin_seq();
        push_fetch(4'h6, 0, 0);
        push(0, 1, 0, B_AS | B_AC | B_NZ | A_NOT);
        push_fetch(4'hE, 0, 0);
        push(0, 1, 0, E_F1);
        push(0, 0, 0, B_AS | B_MR);
        push(0, 1, 0, B_AS | B_MR | B_PI | B_AC | B_NZ | S_MEM);
        push_fetch(4'hC, 0, 0);
        push(0, 1, 0, E_F1);
        push(0, 1, 0, B_AS | B_MR | B_PI | B_RD);
        push(0, 1, 0, B_AS | B_AC | B_NZ | S_IO);
        push_fetch(4'hD, 0, 0);
        push(0, 1, 0, E_F1);
        push(0, 1, 0, B_AS | B_MR | B_PI | B_RD);
        push(0, 1, 0, B_AS | B_IO);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL short_ops step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_illegal();
        begin_seq();
        push_fetch(4'hF, 0, 0);
        for (int k = 0; k < 10; k++) push(0, k[0], 0, B_AS | B_HL);
        push(0, 1, 1, B_AS | B_HL);
        push_fetch(4'h7, 0, 0);
        push(0, 1, 0, B_AS | B_IL);
        push(0, 1, 0, E_F1);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL halt_illegal step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        begin_seq();
        push_fetch(4'h1, 0, 0);
        push_operand(1);
        push(0, 1, 0, B_RM);
        push(0, 0, 0, B_AS | B_MW);
        push(0, 0, 0, B_AS | B_MW);
        push(1, 0, 0, DEF);
        push(0, 0, 0, E_F1);
        push(0, 0, 0, B_AS | B_MR);
        foreach (seq[i]) begin
            apply(seq[i]);
            @(negedge clk);
            checks++;
            if (o8 !== seq[i].exp) begin
                errors++;
                $display("FAIL reset_mid_wait step %0d: outputs=%h expected=%h", i, o8, seq[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_lda8();
        test_mem_ops8();
        test_jmp16();
        test_fetch_wait();
        test_jumps();
        test_short_ops();
        test_halt_illegal();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
